// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: instruction views from D/E, jump and
// data-memory handshake in, stage stall/flush controls and counters out.
//   master: pipeline side (drives instructions and memory handshake)
//   slave : hazard controller (drives stage controls and counters)
interface pipe_hazard_if #(
   parameter int unsigned CNT_W = 16
);
   logic [31:0]      inst_D;
   logic [31:0]      inst_E;
   logic             jump_taken;
   logic             dmem_req;
   logic             dmem_ready;
   logic             err_clr;
   logic             F_stop;
   logic             D_stop;
   logic             E_stop;
   logic             jump_reset;
   logic             E_hold;
   logic             M_hold;
   logic             W_bubble;
   logic             dmem_abort;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output inst_D, inst_E, jump_taken,
      output dmem_req, dmem_ready, err_clr,
      input  F_stop, D_stop, E_stop, jump_reset,
      input  E_hold, M_hold, W_bubble,
      input  dmem_abort, mem_err,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  inst_D, inst_E, jump_taken,
      input  dmem_req, dmem_ready, err_clr,
      output F_stop, D_stop, E_stop, jump_reset,
      output E_hold, M_hold, W_bubble,
      output dmem_abort, mem_err,
      output stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32I pipeline.
// Ports: clk, rst (async, active-high), hz (pipe_hazard_if.slave bundle).
module pipe_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic         clk,
   input  logic         rst,
   pipe_hazard_if.slave hz
);

   localparam logic [6:0] OP_L   = 7'b0000011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_AR  = 7'b0110011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [7:0]       TO_V    = TIMEOUT[7:0];
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic             err_set;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic [6:0] op_d, op_e;
   logic [4:0] rd_e, rs1_d, rs2_d;
   logic       use_rs1, use_rs2, lu_hazard;
   logic       freeze, lu_stall, jmp;

   // Fields the hazard check never looks at.
   logic unused_bits;
   assign unused_bits = ^{hz.inst_D[14:7], hz.inst_D[31:25],
                          hz.inst_E[31:12]};

   assign op_d  = hz.inst_D[6:0];
   assign op_e  = hz.inst_E[6:0];
   assign rd_e  = hz.inst_E[11:7];
   assign rs1_d = hz.inst_D[19:15];
   assign rs2_d = hz.inst_D[24:20];

   always_comb begin
      use_rs1 = !((op_d == OP_LUI) || (op_d == OP_AUI) ||
                  (op_d == OP_JAL));
      use_rs2 = (op_d == OP_B) || (op_d == OP_S) || (op_d == OP_AR);
      lu_hazard = (op_e == OP_L) && (rd_e != 5'd0) &&
                  ((use_rs1 && (rd_e == rs1_d)) ||
                   (use_rs2 && (rd_e == rs2_d)));
   end

   // Pipeline-wide control terms, priority freeze > jump > load-use.
   always_comb begin
      freeze   = (state_q != ERR) && hz.dmem_req && !hz.dmem_ready;
      jmp      = hz.jump_taken && !freeze;
      lu_stall = lu_hazard && !freeze && !hz.jump_taken;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_set = 1'b0;
      case (state_q)
         RUN: begin
            if (hz.dmem_req && !hz.dmem_ready) begin
               state_d = MEM_WAIT;
               wait_d  = 8'd1;
            end
         end
         MEM_WAIT: begin
            // A withdrawn request ends the wait just like completion.
            if (hz.dmem_ready || !hz.dmem_req) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q == TO_V) begin
               state_d = ERR;
               err_set = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase

      err_d = err_q;
      if (err_set)
         err_d = 1'b1;
      else if (hz.err_clr)
         err_d = 1'b0;

      stall_d = stall_q;
      if ((freeze || lu_stall) && (stall_q != '1))
         stall_d = stall_q + CNT_ONE;

      flush_d = flush_q;
      if (jmp && (flush_q != '1))
         flush_d = flush_q + CNT_ONE;
   end

   // Output logic; everything combinational is quiet while in reset.
   always_comb begin
      hz.F_stop     = 1'b0;
      hz.D_stop     = 1'b0;
      hz.E_stop     = 1'b0;
      hz.jump_reset = 1'b0;
      hz.E_hold     = 1'b0;
      hz.M_hold     = 1'b0;
      hz.W_bubble   = 1'b0;
      hz.dmem_abort = 1'b0;
      if (!rst) begin
         hz.F_stop     = freeze || lu_stall;
         hz.D_stop     = freeze || lu_stall;
         hz.E_stop     = lu_stall;
         hz.jump_reset = jmp;
         hz.E_hold     = freeze;
         hz.M_hold     = freeze;
         // ERR flushes the aborted load out of W.
         hz.W_bubble   = freeze || (state_q == ERR);
         hz.dmem_abort = (state_q == ERR);
      end
   end

   assign hz.mem_err   = err_q;
   assign hz.stall_cnt = stall_q;
   assign hz.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan cases
// followed by randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int TO  = 4;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   localparam logic [6:0] OP_L   = 7'b0000011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_AR  = 7'b0110011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_I   = 7'b0010011;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipe_hazard_if #(.CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(
      .TIMEOUT(TO),
      .CNT_W  (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int f_stop;
      int d_stop;
      int e_stop;
      int jrst;
      int e_hold;
      int m_hold;
      int w_bub;
      int abort;
      int merr;
      int scnt;
      int fcnt;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Model: mode 0 = running, 1 = waiting on memory, 2 = abort cycle
   int m_mode  = 0;
   int m_wait  = 0;
   int m_stall = 0;
   int m_flush = 0;
   int m_err   = 0;

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b010, rd, op};
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [6:0] op;
      case ($urandom_range(0, 7))
         0: op = OP_L;
         1: op = OP_S;
         2: op = OP_B;
         3: op = OP_AR;
         4: op = OP_LUI;
         5: op = OP_AUI;
         6: op = OP_JAL;
         default: op = OP_I;
      endcase
      return mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)));
   endfunction

   // One clock cycle of stimulus; pushes what the outputs must be
   // during this cycle, then advances the model across the next edge.
   task automatic step(input bit r, input logic [31:0] d,
                       input logic [31:0] e, input bit jt,
                       input bit req, input bit rdy, input bit clr);
      exp_t       x;
      logic [6:0] opd, ope;
      logic [4:0] rde;
      bit         u1, u2, hzd, frz, lus, jr, enter_err;
      @(posedge clk);
      #1;
      rst            = r;
      bus.inst_D     = d;
      bus.inst_E     = e;
      bus.jump_taken = jt;
      bus.dmem_req   = req;
      bus.dmem_ready = rdy;
      bus.err_clr    = clr;
      if (r) begin
         x = '{default: 0};
         q.push_back(x);
         m_mode  = 0;
         m_wait  = 0;
         m_stall = 0;
         m_flush = 0;
         m_err   = 0;
      end else begin
         opd = d[6:0];
         ope = e[6:0];
         rde = e[11:7];
         u1  = !(opd == OP_LUI || opd == OP_AUI || opd == OP_JAL);
         u2  = (opd == OP_B || opd == OP_S || opd == OP_AR);
         hzd = (ope == OP_L) && (rde != 0) &&
               ((u1 && rde == d[19:15]) || (u2 && rde == d[24:20]));
         frz = (m_mode != 2) && req && !rdy;
         jr  = jt && !frz;
         lus = hzd && !frz && !jt;
         x.f_stop = int'(frz | lus);
         x.d_stop = int'(frz | lus);
         x.e_stop = int'(lus);
         x.jrst   = int'(jr);
         x.e_hold = int'(frz);
         x.m_hold = int'(frz);
         x.w_bub  = int'(frz || m_mode == 2);
         x.abort  = int'(m_mode == 2);
         x.merr   = m_err;
         x.scnt   = m_stall;
         x.fcnt   = m_flush;
         q.push_back(x);

         if (frz || lus) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
         if (jr)         m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;

         enter_err = 0;
         if (m_mode == 0) begin
            if (req && !rdy) begin
               m_mode = 1;
               m_wait = 1;
            end
         end else if (m_mode == 1) begin
            if (rdy || !req) begin
               m_mode = 0;
               m_wait = 0;
            end else if (m_wait == TO) begin
               m_mode    = 2;
               enter_err = 1;
            end else begin
               m_wait++;
            end
         end else begin
            m_mode = 0;
            m_wait = 0;
         end
         if (enter_err)  m_err = 1;
         else if (clr)   m_err = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 32'h13, 32'h13, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("F_stop",     int'(bus.F_stop),     x.f_stop);
         chk("D_stop",     int'(bus.D_stop),     x.d_stop);
         chk("E_stop",     int'(bus.E_stop),     x.e_stop);
         chk("jump_reset", int'(bus.jump_reset), x.jrst);
         chk("E_hold",     int'(bus.E_hold),     x.e_hold);
         chk("M_hold",     int'(bus.M_hold),     x.m_hold);
         chk("W_bubble",   int'(bus.W_bubble),   x.w_bub);
         chk("dmem_abort", int'(bus.dmem_abort), x.abort);
         chk("mem_err",    int'(bus.mem_err),    x.merr);
         chk("stall_cnt",  int'(bus.stall_cnt),  x.scnt);
         chk("flush_cnt",  int'(bus.flush_cnt),  x.fcnt);
      end
   end

   initial begin
      logic [31:0] lw5, add_use5, lw0, add_x0, lui5, sw_use5;
      lw5      = mk(OP_L, 5, 0, 0);
      add_use5 = mk(OP_AR, 6, 5, 7);
      lw0      = mk(OP_L, 0, 0, 0);
      add_x0   = mk(OP_AR, 6, 0, 0);
      lui5     = mk(OP_LUI, 5, 5, 5);
      sw_use5  = mk(OP_S, 0, 1, 5);

      bus.inst_D     = '0;
      bus.inst_E     = '0;
      bus.jump_taken = 1'b0;
      bus.dmem_req   = 1'b0;
      bus.dmem_ready = 1'b0;
      bus.err_clr    = 1'b0;

      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);

      // Load-use on rs1, then on rs2 of a store
      step(0, add_use5, lw5, 0, 0, 0, 0);
      idle(1);
      step(0, sw_use5, lw5, 0, 0, 0, 0);
      // Benign: x0 destination, lui ignores its rs fields
      step(0, add_x0, lw0, 0, 0, 0, 0);
      step(0, lui5, lw5, 0, 0, 0, 0);
      // Jump beats load-use
      step(0, add_use5, lw5, 1, 0, 0, 0);
      idle(1);

      // Memory wait of 3 cycles then completion
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 32'h13, 32'h13, 0, 1, 0, 0);
      step(0, 32'h13, 32'h13, 0, 1, 1, 0);
      idle(1);

      // Jump held under freeze, released when memory completes
      step(0, add_use5, lw5, 1, 1, 0, 0);
      step(0, add_use5, lw5, 1, 1, 1, 0);
      idle(1);

      // Timeout: five frozen cycles, one abort cycle, sticky error
      for (int i = 0; i < TO + 2; i++) step(0, 32'h13, 32'h13, 0, 1, 0, 0);
      idle(3);
      step(0, 32'h13, 32'h13, 0, 0, 0, 1);
      idle(1);

      // Reset in the middle of a wait
      for (int i = 0; i < 2; i++) step(0, 32'h13, 32'h13, 0, 1, 0, 0);
      step(1, 32'h13, 32'h13, 0, 1, 0, 0);
      idle(1);

      // Counter saturation after 20 stall cycles
      for (int i = 0; i < 20; i++) step(0, add_use5, lw5, 0, 0, 0, 0);
      idle(1);
      @(negedge clk);
      chk("stall_sat", int'(bus.stall_cnt), SAT);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 199) == 0, rnd_inst(), rnd_inst(),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      end

      idle(1);
      @(negedge clk);
      #1;
      chk("queue_drain", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
